// File: rtl/adder_pkg.sv
// Shared configuration for the segment-pipelined adder: default sizes and segment count.
// Latency: none (parameters and elaboration-time helpers only).
// Backpressure: not applicable.
package adder_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_SEG_W = 4;

    function automatic int calc_nseg(input int width, input int seg_w);
        return width / seg_w;
    endfunction

    // Operands must split into a whole number of segments.
    function automatic bit cfg_ok(input int width, input int seg_w);
        return (seg_w > 0) && (width >= seg_w) && ((width % seg_w) == 0);
    endfunction

endpackage

// File: rtl/adder_segment.sv
// SEG_W-bit ripple-carry segment adder, one per pipeline stage.
// Latency: combinational.
// Backpressure: none; the enclosing stage register holds its inputs.
module adder_segment
    import adder_pkg::*;
#(
    parameter int SEG_W = DEF_SEG_W
) (
    input  logic [SEG_W-1:0] a_seg,
    input  logic [SEG_W-1:0] b_seg,
    input  logic             cin,
    output logic [SEG_W-1:0] s_seg,
    output logic             cout
);

    logic c;

    always_comb begin
        c     = cin;
        s_seg = '0;
        for (int i = 0; i < SEG_W; i++) begin
            s_seg[i] = a_seg[i] ^ b_seg[i] ^ c;
            c        = (a_seg[i] & b_seg[i]) | (c & (a_seg[i] ^ b_seg[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/pipelined_adder.sv
// Segment-pipelined add/subtract; PIPELINED_ADDER_OVF_EN adds a registered signed-overflow output.
// Latency: NSEG cycles from presentation to out_valid (one segment resolved per stage).
// Backpressure: whole pipeline holds while out_valid && !out_ready; in_ready drops in the same cycle.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SEG_W = DEF_SEG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
`ifdef PIPELINED_ADDER_OVF_EN
    ,
    output logic             overflow
`endif
);

    localparam int NSEG = calc_nseg(WIDTH, SEG_W);

    if (!cfg_ok(WIDTH, SEG_W)) begin : g_cfg_err
        $error("pipelined_adder: WIDTH must be a non-zero multiple of SEG_W");
    end

    logic advance;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    for (genvar k = 0; k < NSEG; k++) begin : g_stage
        localparam int LO = k * SEG_W;
        // b bits still unconsumed once this stage has taken its own segment
        localparam int BW = (NSEG - 1 - k) * SEG_W;

        logic                v_in;
        logic                c_in;
        logic [WIDTH-1:0]    acc_in;
        logic [BW+SEG_W-1:0] b_in;
        logic [SEG_W-1:0]    s_seg;
        logic                c_out;
        logic [WIDTH-1:0]    acc_nxt;

        logic                vld_q;
        logic                cry_q;
        logic [WIDTH-1:0]    acc_q;

        // acc carries finished result segments below LO and raw a segments from LO upward
        if (k == 0) begin : g_src
            assign v_in   = in_valid;
            assign c_in   = sub;
            assign acc_in = a;
            assign b_in   = b ^ {WIDTH{sub}};
        end else begin : g_src
            assign v_in   = g_stage[k-1].vld_q;
            assign c_in   = g_stage[k-1].cry_q;
            assign acc_in = g_stage[k-1].acc_q;
            assign b_in   = g_stage[k-1].g_b.bop_q;
        end

        adder_segment #(.SEG_W(SEG_W)) u_seg (
            .a_seg (acc_in[LO +: SEG_W]),
            .b_seg (b_in[SEG_W-1:0]),
            .cin   (c_in),
            .s_seg (s_seg),
            .cout  (c_out)
        );

        always_comb begin
            acc_nxt             = acc_in;
            acc_nxt[LO +: SEG_W] = s_seg;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_q <= 1'b0;
                cry_q <= 1'b0;
                acc_q <= '0;
            end else if (advance) begin
                vld_q <= v_in;
                cry_q <= c_out;
                acc_q <= acc_nxt;
            end
        end

        if (k < NSEG - 1) begin : g_b
            logic [BW-1:0] bop_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    bop_q <= '0;
                end else if (advance) begin
                    bop_q <= b_in[BW+SEG_W-1:SEG_W];
                end
            end
        end

`ifdef PIPELINED_ADDER_OVF_EN
        // Last stage still sees the raw a MSB in acc_in and the conditioned b MSB in b_in.
        if (k == NSEG - 1) begin : g_ovf
            logic ovf_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else if (advance) begin
                    ovf_q <= (acc_in[WIDTH-1] == b_in[SEG_W-1]) &&
                             (s_seg[SEG_W-1] != acc_in[WIDTH-1]);
                end
            end
        end
`endif
    end

    assign out_valid = g_stage[NSEG-1].vld_q;
    assign sum       = g_stage[NSEG-1].acc_q;
    assign carry_out = g_stage[NSEG-1].cry_q;
`ifdef PIPELINED_ADDER_OVF_EN
    assign overflow  = g_stage[NSEG-1].g_ovf.ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: directed cases on a 16/4 instance, random sweep on 16/4, 8/8 and 32/8.
module tb_pipelined_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        sub;
    logic        out_ready;
    logic [31:0] a_drv;
    logic [31:0] b_drv;

    logic        rdy16, ov16, c16, ovf16;
    logic [15:0] sum16;
    logic        rdy8, ov8, c8, ovf8;
    logic [7:0]  sum8;
    logic        rdy32, ov32, c32, ovf32;
    logic [31:0] sum32;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

`ifdef PIPELINED_ADDER_OVF_EN
    localparam bit HAS_OVF = 1'b1;
`else
    localparam bit HAS_OVF = 1'b0;
    assign ovf16 = 1'b0;
    assign ovf8  = 1'b0;
    assign ovf32 = 1'b0;
`endif

    pipelined_adder #(.WIDTH(16), .SEG_W(4)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy16),
        .a(a_drv[15:0]), .b(b_drv[15:0]), .sub(sub),
        .out_valid(ov16), .out_ready(out_ready), .sum(sum16), .carry_out(c16)
`ifdef PIPELINED_ADDER_OVF_EN
        , .overflow(ovf16)
`endif
    );

    pipelined_adder #(.WIDTH(8), .SEG_W(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy8),
        .a(a_drv[7:0]), .b(b_drv[7:0]), .sub(sub),
        .out_valid(ov8), .out_ready(out_ready), .sum(sum8), .carry_out(c8)
`ifdef PIPELINED_ADDER_OVF_EN
        , .overflow(ovf8)
`endif
    );

    pipelined_adder #(.WIDTH(32), .SEG_W(8)) u_dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy32),
        .a(a_drv), .b(b_drv), .sub(sub),
        .out_valid(ov32), .out_ready(out_ready), .sum(sum32), .carry_out(c32)
`ifdef PIPELINED_ADDER_OVF_EN
        , .overflow(ovf32)
`endif
    );

    // Reference: {overflow, carry, sum} from plain integer arithmetic on w-bit operands.
    function automatic logic [33:0] model(input int w, input logic [31:0] av, input logic [31:0] bv,
                                          input logic s);
        longint modv, half, ua, ub, r, sa, sb, sr;
        logic   cy, ov;
        modv = longint'(1) << w;
        half = modv >> 1;
        ua   = longint'({32'h0, av}) & (modv - 1);
        ub   = longint'({32'h0, bv}) & (modv - 1);
        r    = s ? (ua - ub) : (ua + ub);
        cy   = s ? (ua >= ub) : (r >= modv);
        sa   = (ua >= half) ? ua - modv : ua;
        sb   = (ub >= half) ? ub - modv : ub;
        sr   = s ? (sa - sb) : (sa + sb);
        ov   = HAS_OVF && ((sr < -half) || (sr >= half));
        r    = r & (modv - 1);
        return {ov, cy, r[31:0]};
    endfunction

    logic [33:0] q16[$];
    logic [33:0] q8[$];
    logic [33:0] q32[$];

    task automatic run_one(input logic [15:0] av, input logic [15:0] bv, input logic s,
                           output logic [15:0] rs, output logic rc, output logic ro, output int lat);
        rs = '0; rc = 1'b0; ro = 1'b0; lat = -1;
        @(negedge clk);
        a_drv = {16'h0, av}; b_drv = {16'h0, bv}; sub = s;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int n = 0; n < 20 && lat < 0; n++) begin
            @(negedge clk);
            if (ov16) begin
                lat = n; rs = sum16; rc = c16; ro = ovf16;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; sub = 1'b0;
        a_drv = $urandom; b_drv = $urandom;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_total++; if (ov16 !== 1'b0) $display("FAIL rst_out_valid got=%b want=0", ov16); else n_pass++;
        n_total++; if (sum16 !== 16'h0000) $display("FAIL rst_sum got=%h want=0000", sum16); else n_pass++;
        n_total++; if (c16 !== 1'b0) $display("FAIL rst_carry got=%b want=0", c16); else n_pass++;
        n_total++; if (rdy16 !== 1'b1) $display("FAIL rst_in_ready got=%b want=1", rdy16); else n_pass++;
`ifdef PIPELINED_ADDER_OVF_EN
        n_total++; if (ovf16 !== 1'b0) $display("FAIL rst_overflow got=%b want=0", ovf16); else n_pass++;
`endif
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_add();
        logic [15:0] rs; logic rc, ro; int lat;
        run_one(16'h00FF, 16'h0001, 1'b0, rs, rc, ro, lat);
        n_total++; if (lat !== 3) $display("FAIL add_latency got=%0d want=3", lat); else n_pass++;
        n_total++; if (rs !== 16'h0100) $display("FAIL add_sum got=%h want=0100", rs); else n_pass++;
        n_total++; if (rc !== 1'b0) $display("FAIL add_carry got=%b want=0", rc); else n_pass++;
`ifdef PIPELINED_ADDER_OVF_EN
        n_total++; if (ro !== 1'b0) $display("FAIL add_overflow got=%b want=0", ro); else n_pass++;
`endif
    endtask

    task automatic test_wrap();
        logic [15:0] rs; logic rc, ro; int lat;
        run_one(16'hFFFF, 16'h0001, 1'b0, rs, rc, ro, lat);
        n_total++; if (rs !== 16'h0000 || lat !== 3) $display("FAIL wrap_sum got=%h lat=%0d want=0000 lat=3", rs, lat); else n_pass++;
        n_total++; if (rc !== 1'b1) $display("FAIL wrap_carry got=%b want=1", rc); else n_pass++;
`ifdef PIPELINED_ADDER_OVF_EN
        n_total++; if (ro !== 1'b0) $display("FAIL wrap_overflow got=%b want=0", ro); else n_pass++;
`endif
        run_one(16'h7FFF, 16'h0001, 1'b0, rs, rc, ro, lat);
        n_total++; if (rs !== 16'h8000 || lat !== 3) $display("FAIL sgn_sum got=%h lat=%0d want=8000 lat=3", rs, lat); else n_pass++;
        n_total++; if (rc !== 1'b0) $display("FAIL sgn_carry got=%b want=0", rc); else n_pass++;
`ifdef PIPELINED_ADDER_OVF_EN
        n_total++; if (ro !== 1'b1) $display("FAIL sgn_overflow got=%b want=1", ro); else n_pass++;
`endif
    endtask

    task automatic test_subtract();
        logic [15:0] rs; logic rc, ro; int lat;
        run_one(16'h0003, 16'h0005, 1'b1, rs, rc, ro, lat);
        n_total++; if (rs !== 16'hFFFE || lat !== 3) $display("FAIL sub_neg_sum got=%h lat=%0d want=fffe lat=3", rs, lat); else n_pass++;
        n_total++; if (rc !== 1'b0) $display("FAIL sub_neg_carry got=%b want=0", rc); else n_pass++;
        run_one(16'h0005, 16'h0003, 1'b1, rs, rc, ro, lat);
        n_total++; if (rs !== 16'h0002) $display("FAIL sub_pos_sum got=%h want=0002", rs); else n_pass++;
        n_total++; if (rc !== 1'b1) $display("FAIL sub_pos_carry got=%b want=1", rc); else n_pass++;
        run_one(16'h8000, 16'h0001, 1'b1, rs, rc, ro, lat);
        n_total++; if (rs !== 16'h7FFF) $display("FAIL sub_ovf_sum got=%h want=7fff", rs); else n_pass++;
        n_total++; if (rc !== 1'b1) $display("FAIL sub_ovf_carry got=%b want=1", rc); else n_pass++;
`ifdef PIPELINED_ADDER_OVF_EN
        n_total++; if (ro !== 1'b1) $display("FAIL sub_overflow got=%b want=1", ro); else n_pass++;
`endif
    endtask

    task automatic test_backpressure();
        int sent = 0, got = 0, stall = 0;
        bit seen_first = 1'b0;
        logic [33:0] bq[$];
        logic [33:0] exp_v;
        for (int cyc = 0; cyc < 200 && got < 8; cyc++) begin
            @(negedge clk);
            in_valid = (sent < 8);
            a_drv = 32'(sent);
            b_drv = 32'(sent) << 8;
            sub = 1'b0;
            if (ov16 && !seen_first) begin
                seen_first = 1'b1;
                stall = 3;
            end
            out_ready = (stall == 0);
            #1;
            if (stall > 0) begin
                n_total++; if (rdy16 !== 1'b0) $display("FAIL bp_in_ready got=%b want=0", rdy16); else n_pass++;
                n_total++;
                if (bq.size() == 0 || ov16 !== 1'b1 || sum16 !== bq[0][15:0])
                    $display("FAIL bp_hold got=%h vld=%b want=0000 vld=1", sum16, ov16);
                else n_pass++;
                stall--;
            end
            if (ov16 && out_ready) begin
                n_total++;
                if (bq.size() == 0) begin
                    $display("FAIL bp_extra got=%h want=none", sum16);
                end else begin
                    exp_v = bq.pop_front();
                    if (sum16 !== exp_v[15:0] || c16 !== exp_v[32])
                        $display("FAIL bp_result got=%h/%b want=%h/%b", sum16, c16, exp_v[15:0], exp_v[32]);
                    else n_pass++;
                end
                got++;
            end
            if (in_valid && rdy16) begin
                bq.push_back(model(16, a_drv, b_drv, 1'b0));
                sent++;
            end
        end
        n_total++; if (got != 8 || sent != 8) $display("FAIL bp_count got=%0d sent=%0d want=8", got, sent); else n_pass++;
        in_valid = 1'b0; out_ready = 1'b1;
    endtask

    task automatic test_reset_midflight();
        int leaked = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1; a_drv = 32'hA000 + 32'(i); b_drv = 32'h1; sub = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        n_total++; if (ov16 !== 1'b1) $display("FAIL mid_pre_valid got=%b want=1", ov16); else n_pass++;
        rst = 1'b1;
        #1;
        n_total++; if (ov16 !== 1'b0 || sum16 !== 16'h0 || c16 !== 1'b0)
            $display("FAIL mid_clear got=%b/%h/%b want=0/0000/0", ov16, sum16, c16); else n_pass++;
        n_total++; if (rdy16 !== 1'b1) $display("FAIL mid_in_ready got=%b want=1", rdy16); else n_pass++;
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (ov16 || ov8 || ov32) leaked++;
        end
        n_total++; if (leaked != 0) $display("FAIL mid_leak got=%0d want=0", leaked); else n_pass++;
    endtask

    task automatic test_sweep();
        int acc16 = 0;
        logic [33:0] e;
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        q16.delete(); q8.delete(); q32.delete();
        for (int cyc = 0; cyc < 80000 && (acc16 < 10000 || in_valid || q16.size() || q8.size() || q32.size()); cyc++) begin
            @(negedge clk);
            in_valid  = (acc16 < 10000) && ($urandom_range(0, 4) != 0);
            a_drv     = $urandom;
            b_drv     = $urandom;
            sub       = 1'($urandom_range(0, 1));
            out_ready = (acc16 >= 10000) || ($urandom_range(0, 3) != 0);
            #1;
            if (ov16 && out_ready) begin
                n_total++;
                if (q16.size() == 0) $display("FAIL sw16_extra got=%h want=none", sum16);
                else begin
                    e = q16.pop_front();
                    if ({ovf16, c16, sum16} !== {e[33], e[32], e[15:0]})
                        $display("FAIL sw16 got=%b/%b/%h want=%b/%b/%h", ovf16, c16, sum16, e[33], e[32], e[15:0]);
                    else n_pass++;
                end
            end
            if (ov8 && out_ready) begin
                n_total++;
                if (q8.size() == 0) $display("FAIL sw8_extra got=%h want=none", sum8);
                else begin
                    e = q8.pop_front();
                    if ({ovf8, c8, sum8} !== {e[33], e[32], e[7:0]})
                        $display("FAIL sw8 got=%b/%b/%h want=%b/%b/%h", ovf8, c8, sum8, e[33], e[32], e[7:0]);
                    else n_pass++;
                end
            end
            if (ov32 && out_ready) begin
                n_total++;
                if (q32.size() == 0) $display("FAIL sw32_extra got=%h want=none", sum32);
                else begin
                    e = q32.pop_front();
                    if ({ovf32, c32, sum32} !== e)
                        $display("FAIL sw32 got=%b/%b/%h want=%b/%b/%h", ovf32, c32, sum32, e[33], e[32], e[31:0]);
                    else n_pass++;
                end
            end
            if (in_valid && rdy16) begin q16.push_back(model(16, a_drv, b_drv, sub)); acc16++; end
            if (in_valid && rdy8)  q8.push_back(model(8, a_drv, b_drv, sub));
            if (in_valid && rdy32) q32.push_back(model(32, a_drv, b_drv, sub));
        end
        in_valid = 1'b0;
        n_total++; if (acc16 < 10000) $display("FAIL sw_beats got=%0d want=10000", acc16); else n_pass++;
        n_total++; if (q16.size() + q8.size() + q32.size() != 0)
            $display("FAIL sw_drain got=%0d/%0d/%0d want=0/0/0", q16.size(), q8.size(), q32.size()); else n_pass++;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; sub = 1'b0; out_ready = 1'b1;
        a_drv = '0; b_drv = '0;
        test_reset();
        test_single_add();
        test_wrap();
        test_subtract();
        test_backpressure();
        test_reset_midflight();
        test_sweep();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pipelined_adder.md
# pipelined_adder

Parametrised, segment-pipelined add/subtract unit for the MAC datapath. It splits a WIDTH-bit operation into NSEG = WIDTH/SEG_W segments and resolves one segment per stage, with the carry passed between stage registers. It accepts one operation per cycle on a valid/ready handshake and delivers results in order with fixed latency. It replaces the single-cycle 8-bit ripple adder wherever wider operands or a higher clock rate are needed.

## Interface
- WIDTH, 16, operand and result width; must be a multiple of SEG_W.
- SEG_W, 4, bits resolved per pipeline stage; NSEG = WIDTH/SEG_W ≥ 1.
- clk  in  1  single clock, all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  unit can accept a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- sub  in  1  0: a+b; 1: a-b.
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- carry_out  out  1  carry out of the MSB. For sub, 1 = no borrow (a ≥ b unsigned).
- overflow  out  1  signed (two's-complement) overflow; present only with PIPELINED_ADDER_OVF_EN.

## Operation
- Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
- Subtract is computed as a + ~b + 1. The segment-0 carry-in is sub, and the b segments are inverted when sub=1.
- Stage k (0..NSEG-1) holds:
  - valid_k;
  - result segments 0..k;
  - carry out of segment k;
  - unprocessed a/b segments k+1..NSEG-1 (b already conditioned);
  - the operand MSBs (for overflow).
- Each stage adds its segment with the incoming carry using a SEG_W-bit ripple segment adder.
- Global advance = !out_valid || out_ready. The whole pipeline shifts only on advance. in_ready = advance.
- Bubbles are not collapsed. An invalid beat shifts through like data with valid=0.
- Results leave in acceptance order. There is no reordering, dropping or duplication.
- NSEG=1 degenerates to a single registered stage.

## Timing
- Reset values: all valid_k=0, out_valid=0, sum=0, carry_out=0, overflow=0. in_ready=1 during and after reset.
- Latency: a beat accepted at edge t appears with out_valid=1 after edge t+NSEG-1, i.e. NSEG cycles after presentation when there is no stall.
- Throughput: one beat per cycle while out_ready=1.
- Stall: out_valid=1 && out_ready=0 gives in_ready=0 in the same cycle (combinational), and every stage register holds. sum, carry_out and overflow stay stable until accepted.
- Simultaneous output accept and input accept in one cycle are allowed; the pipeline shifts.
- Reset asserted mid-operation clears all valids immediately. In-flight beats are discarded and no partial result is presented.
- Outputs are driven only from the last stage registers, so there are no combinational paths from a/b to sum.

## Configuration
- PIPELINED_ADDER_OVF_EN defined:
  - The overflow port exists.
  - The last stage computes overflow = (a_msb == b'_msb) && (sum_msb != a_msb), where b' is the conditioned operand.
  - overflow is registered with sum and follows the same valid/stall rules.
- Undefined: the port and its pipeline bits are absent, and the remaining behaviour is identical.

## Structure
- Shared package `adder_pkg`:
  - default WIDTH/SEG_W;
  - NSEG derivation;
  - a compile-time check that WIDTH % SEG_W == 0.
- Sub-module `adder_segment`: combinational SEG_W-bit ripple add (a_seg, b_seg, cin → s_seg, cout). It is instantiated once per stage.
- Stage registers, the advance/handshake logic and the overflow logic live in `pipelined_adder`.

## Test plan
All scenarios use WIDTH=16, SEG_W=4, NSEG=4 unless stated.
- Reset: assert rst with in_valid=1 → out_valid=0, sum=0x0000, carry_out=0, in_ready=1.
- Single add: 0x00FF + 0x0001, sub=0 → the beat accepted at edge t appears with out_valid=1 after edge t+3, sum=0x0100, carry_out=0. With OVF_EN, overflow=0.
- Wrap and carry:
  - 0xFFFF + 0x0001 → sum=0x0000, carry_out=1, overflow=0.
  - 0x7FFF + 0x0001 → sum=0x8000, carry_out=0, overflow=1.
- Subtract:
  - 0x0003 - 0x0005 → sum=0xFFFE, carry_out=0.
  - 0x0005 - 0x0003 → sum=0x0002, carry_out=1.
  - 0x8000 - 0x0001 → sum=0x7FFF, overflow=1.
- Backpressure: stream 8 back-to-back beats (a=i, b=0x0100·i, sub=0), holding out_ready=0 for 3 cycles after the first result → in_ready=0 in those cycles, sum held steady, all 8 results delivered in order, none lost or duplicated.
- Reset mid-flight plus sweep:
  - Assert rst with 3 beats in flight → out_valid=0 immediately, and none of the 3 results ever emerges.
  - Then compare 10k random add/sub beats, with random out_ready, against a±b mod 2^16, for (WIDTH, SEG_W) = (16,4), (8,8) and (32,8).
